// File: rtl/core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter
//
// Shares a single Avalon-MM master port to system memory between the core's
// instruction-fetch port (I) and data port (D). Each core port is an Avalon-MM
// slave with waitrequest. One transaction is in flight at a time: the command
// is latched at grant, replayed to memory until accepted, and completed to the
// owning requester with a one-cycle waitrequest-low pulse.
//
// Arbitration: D wins over I, except that after MAX_D_STREAK consecutive D
// grants taken while a fetch was waiting, the next contended grant goes to I.
//
// Parameters
//   ADDR_W        address width of all ports
//   DATA_W        data width of all ports
//   MAX_D_STREAK  consecutive D grants allowed while a fetch is pending (>=1)
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   i_addr, i_read                     fetch request
//   i_readdata, i_waitrequest          fetch response / stall
//   d_addr, d_read, d_write,
//   d_writedata, d_byteenable          data request
//   d_readdata, d_waitrequest          data response / stall
//   avm_address, avm_read, avm_write,
//   avm_writedata, avm_byteenable      memory command (all registered)
//   avm_readdata, avm_waitrequest,
//   avm_readdatavalid                  memory response / stall
// -----------------------------------------------------------------------------
module core_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // instruction-fetch slave
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_read,
  output logic [DATA_W-1:0]     i_readdata,
  output logic                  i_waitrequest,
  // data slave
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_W-1:0]     d_writedata,
  input  logic [DATA_W/8-1:0]   d_byteenable,
  output logic [DATA_W-1:0]     d_readdata,
  output logic                  d_waitrequest,
  // memory master
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest,
  input  logic                  avm_readdatavalid
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);
  localparam logic [STREAK_W-1:0] STREAK_ZERO = STREAK_W'(0);

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [STREAK_W-1:0]   r_d_streak;
  logic                  r_owner;
  logic                  r_is_write;
  logic [DATA_W-1:0]     r_rdata;

  state_t                w_next_state;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_is_write_next;
  logic [DATA_W-1:0]     w_rdata_next;
  logic [STREAK_W-1:0]   w_streak_next;
  logic                  w_i_pend;
  logic                  w_d_pend;

  assign w_i_pend = i_read;
  assign w_d_pend = d_read | d_write;

  // Next-state, grant decision, streak update and read-data capture.
  always_comb begin
    w_next_state    = r_state;
    w_grant_i       = 1'b0;
    w_grant_d       = 1'b0;
    w_is_write_next = r_is_write;
    w_rdata_next    = r_rdata;
    w_streak_next   = r_d_streak;
    case (r_state)
      ST_IDLE: begin
        // D wins unless a fetch has already been passed over MAX_D_STREAK times.
        if (w_d_pend && (!w_i_pend || (r_d_streak != STREAK_MAX))) begin
          w_grant_d       = 1'b1;
          w_is_write_next = d_write;   // read+write together is a write
          w_next_state    = ST_ISSUE;
          if (w_i_pend) begin
            // Cannot overflow: this branch is only reached below STREAK_MAX.
            w_streak_next = r_d_streak + STREAK_ONE;
          end else begin
            w_streak_next = STREAK_ZERO;
          end
        end else if (w_i_pend) begin
          w_grant_i       = 1'b1;
          w_is_write_next = 1'b0;
          w_next_state    = ST_ISSUE;
          w_streak_next   = STREAK_ZERO;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!avm_waitrequest) begin
          if (r_is_write) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_RESP;
          end
        end else begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_RESP: begin
        if (avm_readdatavalid) begin
          w_rdata_next = avm_readdata;
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, latched command, and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_d_streak     <= STREAK_ZERO;
      r_owner        <= OWN_I;
      r_is_write     <= 1'b0;
      r_rdata        <= {DATA_W{1'b0}};
      avm_address    <= {ADDR_W{1'b0}};
      avm_writedata  <= {DATA_W{1'b0}};
      avm_byteenable <= {BE_W{1'b0}};
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      i_waitrequest  <= 1'b1;
      d_waitrequest  <= 1'b1;
      i_readdata     <= {DATA_W{1'b0}};
      d_readdata     <= {DATA_W{1'b0}};
    end else begin
      r_state    <= w_next_state;
      r_d_streak <= w_streak_next;
      r_is_write <= w_is_write_next;
      r_rdata    <= w_rdata_next;

      // The command registers double as the avm_* outputs, so they stay
      // frozen from grant until the next grant regardless of requester inputs.
      if (w_grant_d) begin
        r_owner        <= OWN_D;
        avm_address    <= d_addr;
        avm_writedata  <= d_writedata;
        avm_byteenable <= d_byteenable;
      end else if (w_grant_i) begin
        r_owner        <= OWN_I;
        avm_address    <= i_addr;
        avm_writedata  <= {DATA_W{1'b0}};
        avm_byteenable <= {BE_W{1'b1}};
      end

      avm_read  <= (w_next_state == ST_ISSUE) && !w_is_write_next;
      avm_write <= (w_next_state == ST_ISSUE) &&  w_is_write_next;

      // Owner is fixed at grant, which always precedes DONE by two or more cycles.
      i_waitrequest <= !((w_next_state == ST_DONE) && (r_owner == OWN_I));
      d_waitrequest <= !((w_next_state == ST_DONE) && (r_owner == OWN_D));

      if ((w_next_state == ST_DONE) && (r_owner == OWN_I)) begin
        i_readdata <= w_rdata_next;
      end
      if ((w_next_state == ST_DONE) && (r_owner == OWN_D)) begin
        d_readdata <= w_rdata_next;
      end
    end
  end

endmodule
